mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words of storage.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait states per access; range 0..15.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  processor-side request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  processor accepts the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access was misaligned or out of range.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE: req_ready=1, rsp_valid=0; a handshake (req_valid & req_ready) latches req_we, req_addr and req_wdata and moves to WAIT.
REQ-016 On entry to WAIT: wait counter = WAIT_CYCLES; it decrements each cycle; when the counter is 0, the access commits and the FSM moves to RESP on the next edge.
REQ-017 Commit: a store writes word req_addr[31:2]; a load registers mem[req_addr[31:2]] into rsp_rdata.
REQ-018 Latency: rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 In RESP: rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_ready=1, then the FSM returns to IDLE.
REQ-020 req_ready SHALL be 0 in WAIT and RESP; at most one request is outstanding; req_* inputs are ignored outside IDLE.
REQ-021 After a response handshake, the next request is accepted no earlier than the following cycle (IDLE).
REQ-022 Error: if req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS, there is no memory write, rsp_rdata=0, rsp_err=1; timing is unchanged.
REQ-023 A store followed by a load of the same address SHALL return the stored data.
REQ-024 rsp_err=0 and rsp_rdata=0 for a successful store.

Reset
REQ-025 rst SHALL force: state IDLE, req_ready=1 on the following cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
REQ-026 Reset in WAIT SHALL discard the pending access; an uncommitted store SHALL NOT write memory.
REQ-027 Reset in RESP SHALL drop the response without a handshake.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro MEM_RESPONDER_WAIT_EN: when defined, the WAIT state and counter are honoured as in REQ-016 and REQ-018.
REQ-030 When MEM_RESPONDER_WAIT_EN is undefined, WAIT_CYCLES is ignored; commit happens in the cycle after accept, and rsp_valid rises 1 cycle after accept (same as WAIT_CYCLES=0).

Structure
REQ-031 Package mem_resp_pkg SHALL hold the state enum (IDLE/WAIT/RESP), ADDR_W=32, DATA_W=32 and the error-check helper constant widths.
REQ-032 Storage SHALL be the sub-module mem_array (word array with synchronous write and registered read, port: clk, we, addr, wdata, rdata); mem_responder holds the FSM, counter and error logic.

Verification
REQ-033 WAIT_CYCLES=2, macro defined: store 0xDEADBEEF to 0x10 -> rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0; then load 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-034 Load 0x12 (misaligned) and load 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0; a prior value at 0x10 is unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0; rsp_ready=1 -> IDLE on the next cycle.
REQ-036 Store 0x12345678 to 0x20, assert rst on the first WAIT cycle -> all outputs at reset values; a later load of 0x20 returns the old contents.
REQ-037 Macro undefined, WAIT_CYCLES=7 -> every access has rsp_valid 1 cycle after accept.
REQ-038 Drive back-to-back requests with rsp_ready=1 -> one accept per 3+WAIT_CYCLES cycles; no request accepted while req_ready=0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared widths, FSM state encodings and address check for mem_responder
package mem_resp_pkg;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int WORD_LSB = 2;
   localparam int CNT_W    = 4;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t WAIT = 2'd1;
   localparam state_t RESP = 2'd2;

   // Misaligned byte address or word index at/after the end of storage.
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] depth);
      return (addr[WORD_LSB-1:0] != '0) ||
             ({{WORD_LSB{1'b0}}, addr[ADDR_W-1:WORD_LSB]} >= depth);
   endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with synchronous write and registered read, no reset
module mem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder; MEM_RESPONDER_WAIT_EN enables wait states
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

`ifdef MEM_RESPONDER_WAIT_EN
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
`else
   // Wait states disabled: every access behaves as WAIT_CYCLES = 0.
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES * 0);
`endif

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem_rdata;
   logic              err;
   logic              commit;
   logic              mem_we;

   assign err    = addr_err(addr_q, DEPTH_LIM);
   assign commit = (state == WAIT) && (cnt == '0);
   // Reset on the commit edge must still block the write.
   assign mem_we = commit && we_q && !err && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  cnt     <= WAIT_LOAD;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (commit) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mem_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (IDX_W),
      .DW    (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (addr_q[IDX_W+WORD_LSB-1:WORD_LSB]),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   // The read register keeps re-reading the latched address; nothing writes while in RESP.
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_err   = (state == RESP) && err;
   assign rsp_rdata = ((state == RESP) && !we_q && !err) ? mem_rdata : '0;

endmodule
